round_sequencer: RTL and testbench
==================================

# round_sequencer

Runs one round of the memory game for a logged-in player. On a start press it generates a pseudo-random symbol sequence whose length is set by the current level and plays it to the display. It then checks the player's repeated entries and issues a one-cycle `win` or `lose` pulse. It sits downstream of the level controller, consuming `level_num`, and feeds `win` back to it.

## Interface
Parameters:
- `SHOW_CYCLES`, default 4: cycles each symbol is held on the display.
- `GAP_CYCLES`, default 2: blank cycles after each displayed symbol.
- `TIMEOUT_CYCLES`, default 64: entry timeout. Used only with `ROUND_TIMEOUT_EN`.

Ports:
- `clock` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `auth_bit` in 1: player authenticated. Rounds start only when this is 1.
- `log_out` in 1: abort request.
- `rng_button` in 1: start request, level-sampled.
- `level_num` in 4: current level. Sequence length is `level_num`+1 (1..16).
- `user_valid` in 1: one-cycle strobe for a player entry.
- `user_symbol` in 2: the player's entered symbol.
- `display_valid` out 1: a symbol is being shown.
- `display_symbol` out 2: the symbol being shown.
- `busy` out 1: a round is in progress.
- `win` out 1: one-cycle pulse on full correct repeat.
- `lose` out 1: one-cycle pulse on a wrong entry or timeout.

## Operation
- **LFSR.** 16-bit Fibonacci LFSR with taps 16,14,13,11. Shifts left; the feedback bit enters bit 0. Reset value is 16'hACE1.
  - Free-runs one step per cycle in IDLE.
  - The current symbol is `lfsr[1:0]`.
- **States:** IDLE, SHOW, GAP, WAIT_IN, WIN, LOSE.
- **IDLE → SHOW.** Taken when `rng_button`=1, `auth_bit`=1 and `log_out`=0. On that edge:
  - capture `seed`←lfsr and `len`←`level_num`;
  - set `idx`←0 and `lfsr`←lfsr, so the generator starts from the seed.
- **SHOW.** `display_valid`=1, `display_symbol`=`lfsr[1:0]`.
  - Holds for SHOW_CYCLES cycles, then goes to GAP.
- **GAP.** `display_valid`=0, holds for GAP_CYCLES cycles. On exit the LFSR steps once.
  - If `idx`==`len`: go to WAIT_IN, reload `lfsr`←`seed`, set `idx`←0.
  - Otherwise: `idx`++ and go back to SHOW.
- **WAIT_IN.** On each `user_valid`, compare `user_symbol` with `lfsr[1:0]`.
  - Mismatch: go to LOSE.
  - Match and `idx`==`len`: go to WIN.
  - Match otherwise: step the LFSR, `idx`++, stay in WAIT_IN.
- **WIN / LOSE.** Each lasts exactly one cycle, asserting `win` or `lose` respectively, then returns to IDLE.
- The LFSR is frozen except at the steps stated above: it does not step in SHOW, in GAP other than on exit, or in WAIT_IN without a `user_valid` match.
- **Abort.** `log_out`=1 or `auth_bit`=0 in any non-IDLE state sends the block to IDLE on the next edge.
  - Abort takes priority over `user_valid` and over the WIN/LOSE transitions.
  - No `win` or `lose` pulse is produced.
- **Ignored inputs:**
  - `rng_button` outside IDLE;
  - `user_valid` outside WAIT_IN;
  - `level_num` changes after capture.
- **Width rules.** `len` and `idx` are 4 bits. `len`=15 yields 16 symbols; `idx` never wraps because comparison happens before increment.

## Timing
- **Reset values:** state IDLE, `lfsr`=16'hACE1, `seed`=16'hACE1, counters 0, and all outputs 0.
- Start accepted at edge N: `busy`=1 and `display_valid`=1 from cycle N+1.
- Each symbol occupies SHOW_CYCLES+GAP_CYCLES cycles. Display of L symbols takes L·(SHOW_CYCLES+GAP_CYCLES) cycles.
- `win`/`lose` assert in the cycle after the deciding `user_valid` edge. `busy` drops the cycle after the pulse.
- `busy`=1 in every state except IDLE, including WIN and LOSE.
- Outputs are registered. No combinational path exists from inputs to outputs.

## Configuration
- **`ROUND_TIMEOUT_EN` defined:** a counter clears on entry to WAIT_IN and on every `user_valid`. When it reaches TIMEOUT_CYCLES without a valid entry, the block goes to LOSE.
- **`ROUND_TIMEOUT_EN` undefined:** WAIT_IN waits indefinitely. No timeout counter is synthesized.

## Test plan
- **Reset/idle:** assert `rst` mid-SHOW → all outputs 0 immediately and `lfsr`=16'hACE1. Release `rst`, then hold all inputs 0 for 10 cycles → `busy`=0 throughout.
- **Level 0 round:** `level_num`=0, `auth_bit`=1, pulse `rng_button` → 1 symbol displayed for 4 cycles, then 2 blank cycles. Enter the model-predicted symbol → `win`=1 for exactly 1 cycle, then `busy`=0.
- **Level 3 wrong entry:** 4 symbols displayed (24 cycles). The 3rd entry is wrong → `lose` pulse, `win` never asserts, 4th entry ignored.
- **Abort:** `log_out`=1 during WAIT_IN in the same cycle as a correct final `user_valid` → IDLE next cycle, no `win`.
- **Gating:** `rng_button`=1 with `auth_bit`=0 → stays IDLE. `rng_button` pulsed mid-round → no restart, `idx` sequence unchanged.
- **Timeout (`ROUND_TIMEOUT_EN` defined):** no entry for 64 cycles in WAIT_IN → `lose` pulse. With the macro undefined, 1000 idle cycles → still `busy`=1 in WAIT_IN.

Source files
------------

// File: rtl/round_sequencer.sv
// Memory-game round engine: shows an LFSR-generated symbol sequence, then scores the player's repeat.
// Define ROUND_TIMEOUT_EN to add an entry timeout that forces a loss when the player stalls.
module round_sequencer #(
    parameter int unsigned SHOW_CYCLES    = 4,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       auth_bit,
    input  logic       log_out,
    input  logic       rng_button,
    input  logic [3:0] level_num,
    input  logic       user_valid,
    input  logic [1:0] user_symbol,
    output logic       display_valid,
    output logic [1:0] display_symbol,
    output logic       busy,
    output logic       win,
    output logic       lose
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHOW,
        S_GAP,
        S_WAIT_IN,
        S_WIN,
        S_LOSE
    } state_e;

    localparam int unsigned CNT_MAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    state_e           state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [15:0]      seed_q, seed_d;
    logic [3:0]       len_q, len_d;
    logic [3:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      lfsr_step;
    logic             abort;

`ifdef ROUND_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    // Fibonacci taps 16,14,13,11 shifted left, feedback entering bit 0.
    assign lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign abort     = log_out || !auth_bit;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= 16'hACE1;
            seed_q  <= 16'hACE1;
            len_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
`ifdef ROUND_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            seed_q  <= seed_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
`ifdef ROUND_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    // NOTE: every variable gets a hold default first, so no path through this block infers a latch.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        seed_d  = seed_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
`ifdef ROUND_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        if (state_q != S_IDLE && abort) begin
            // Abort outranks entries and pulses, and leaves the generator frozen.
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (rng_button && auth_bit && !log_out) begin
                        state_d = S_SHOW;
                        seed_d  = lfsr_q;
                        len_d   = level_num;
                        idx_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        lfsr_d = lfsr_step;
                    end
                end
                S_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d = S_GAP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d = '0;
                        if (idx_q == len_q) begin
                            // Replay starts from the seed so entries are checked against the same stream.
                            state_d = S_WAIT_IN;
                            lfsr_d  = seed_q;
                            idx_d   = '0;
`ifdef ROUND_TIMEOUT_EN
                            tmo_d   = '0;
`endif
                        end else begin
                            state_d = S_SHOW;
                            lfsr_d  = lfsr_step;
                            idx_d   = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_WAIT_IN: begin
                    if (user_valid) begin
`ifdef ROUND_TIMEOUT_EN
                        tmo_d = '0;
`endif
                        if (user_symbol != lfsr_q[1:0]) begin
                            state_d = S_LOSE;
                        end else if (idx_q == len_q) begin
                            state_d = S_WIN;
                        end else begin
                            lfsr_d = lfsr_step;
                            idx_d  = idx_q + 1'b1;
                        end
                    end
`ifdef ROUND_TIMEOUT_EN
                    else if (tmo_q == TMO_LAST) begin
                        state_d = S_LOSE;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
`endif
                end
                S_WIN, S_LOSE: state_d = S_IDLE;
                default:       state_d = S_IDLE;
            endcase
        end
    end

    // Outputs decode registered state only; nothing reaches them from the inputs combinationally.
    always_comb begin
        display_valid  = 1'b0;
        display_symbol = 2'b00;
        busy           = (state_q != S_IDLE);
        win            = 1'b0;
        lose           = 1'b0;
        case (state_q)
            S_SHOW: begin
                display_valid  = 1'b1;
                display_symbol = lfsr_q[1:0];
            end
            S_WIN:   win  = 1'b1;
            S_LOSE:  lose = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_round_sequencer.sv
// Self-checking bench for round_sequencer: directed round table, gating table, abort/reset/timeout
// sequences and randomized rounds scored against a transaction-level model of the symbol stream.
module tb_round_sequencer;

    localparam int SHOW = 4;
    localparam int GAP  = 2;
`ifdef ROUND_TIMEOUT_EN
    localparam int TMO  = 64;
`endif

    logic       clock = 1'b0;
    logic       rst = 1'b1;
    logic       auth_bit = 1'b0;
    logic       log_out = 1'b0;
    logic       rng_button = 1'b0;
    logic [3:0] level_num = 4'd0;
    logic       user_valid = 1'b0;
    logic [1:0] user_symbol = 2'd0;
    logic       display_valid;
    logic [1:0] display_symbol;
    logic       busy;
    logic       win;
    logic       lose;

    int n_checks = 0;
    int n_errors = 0;

    // Model: generator value the DUT should hold, and the expected stream of the current round.
    logic [15:0] m_lfsr;
    logic [15:0] exp_st [$];
    logic [1:0]  exp_seq [$];

    typedef struct {
        int lvl;
        int err;
        int gap;
        int poke;
        bit exp_win;
        bit exp_lose;
    } round_vec_t;

    typedef struct {
        bit auth;
        bit lout;
        bit rng;
        bit exp_busy;
    } gate_vec_t;

    round_vec_t rtbl [6];
    gate_vec_t  gtbl [4];
    int         bad;
    bit         gw, gl;

    round_sequencer #(
        .SHOW_CYCLES(SHOW),
        .GAP_CYCLES (GAP)
    ) dut (
        .clock         (clock),
        .rst           (rst),
        .auth_bit      (auth_bit),
        .log_out       (log_out),
        .rng_button    (rng_button),
        .level_num     (level_num),
        .user_valid    (user_valid),
        .user_symbol   (user_symbol),
        .display_valid (display_valid),
        .display_symbol(display_symbol),
        .busy          (busy),
        .win           (win),
        .lose          (lose)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        int unsigned v;
        int unsigned fb;
        v  = x;
        fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
        return 16'((v << 1) | fb);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        rng_button = 1'b0;
        user_valid = 1'b0;
        repeat (n) begin
            tick();
            m_lfsr = lfsr_next(m_lfsr);
            check("idle_busy", busy, 0);
        end
    endtask

    task automatic start(input int lvl);
        logic [15:0] s;
        exp_st.delete();
        exp_seq.delete();
        s = m_lfsr;
        for (int i = 0; i <= lvl; i++) begin
            exp_st.push_back(s);
            exp_seq.push_back(s[1:0]);
            s = lfsr_next(s);
        end
        level_num  = 4'(lvl);
        auth_bit   = 1'b1;
        log_out    = 1'b0;
        rng_button = 1'b1;
        tick();
        rng_button = 1'b0;
        level_num  = 4'($urandom);
        check("start_busy", busy, 1);
        check("start_dv", display_valid, 1);
    endtask

    task automatic show_seq(input int poke);
        for (int i = 0; i < exp_seq.size(); i++) begin
            for (int c = 0; c < SHOW; c++) begin
                check("show_dv", display_valid, 1);
                check("show_sym", display_symbol, exp_seq[i]);
                rng_button = (i == poke && c == 1);
                tick();
            end
            rng_button = 1'b0;
            for (int c = 0; c < GAP; c++) begin
                check("gap_dv", display_valid, 0);
                check("gap_busy", busy, 1);
                tick();
            end
        end
        check("wait_busy", busy, 1);
        check("wait_dv", display_valid, 0);
    endtask

    task automatic enter(input logic [1:0] sym, input logic lout);
        user_valid  = 1'b1;
        user_symbol = sym;
        log_out     = lout;
        tick();
        user_valid  = 1'b0;
        log_out     = 1'b0;
    endtask

    task automatic play(input int lvl, input int err, input int gap, input int poke,
                        output bit got_win, output bit got_lose);
        got_win  = 1'b0;
        got_lose = 1'b0;
        idle(gap);
        start(lvl);
        show_seq(poke);
        for (int k = 0; k <= lvl; k++) begin
            int pause;
            pause = $urandom_range(0, 2);
            repeat (pause) begin
                tick();
                check("wait_hold", {busy, win, lose}, 3'b100);
            end
            if (k == err) begin
                enter(exp_seq[k] ^ 2'($urandom_range(1, 3)), 1'b0);
                got_win  = win;
                got_lose = lose;
                check("lose_pulse", lose, 1);
                check("lose_nowin", win, 0);
                m_lfsr = exp_st[k];
                if (k < lvl) begin
                    user_valid  = 1'b1;
                    user_symbol = exp_seq[k+1];
                end
                tick();
                user_valid = 1'b0;
                check("after_lose", {busy, win, lose}, 3'b000);
                return;
            end
            enter(exp_seq[k], 1'b0);
            if (k == lvl) begin
                got_win  = win;
                got_lose = lose;
                check("win_pulse", win, 1);
                check("win_nolose", lose, 0);
                m_lfsr = exp_st[k];
                tick();
                check("after_win", {busy, win, lose}, 3'b000);
            end else begin
                check("mid_entry", {busy, win, lose}, 3'b100);
            end
        end
    endtask

    initial begin
        rtbl[0] = '{lvl: 0,  err: 99, gap: 0, poke: -1, exp_win: 1'b1, exp_lose: 1'b0};
        rtbl[1] = '{lvl: 3,  err: 2,  gap: 1, poke: -1, exp_win: 1'b0, exp_lose: 1'b1};
        rtbl[2] = '{lvl: 15, err: 99, gap: 3, poke: 5,  exp_win: 1'b1, exp_lose: 1'b0};
        rtbl[3] = '{lvl: 1,  err: 0,  gap: 0, poke: 0,  exp_win: 1'b0, exp_lose: 1'b1};
        rtbl[4] = '{lvl: 7,  err: 7,  gap: 2, poke: -1, exp_win: 1'b0, exp_lose: 1'b1};
        rtbl[5] = '{lvl: 2,  err: 99, gap: 4, poke: 1,  exp_win: 1'b1, exp_lose: 1'b0};

        gtbl[0] = '{auth: 1'b0, lout: 1'b0, rng: 1'b1, exp_busy: 1'b0};
        gtbl[1] = '{auth: 1'b1, lout: 1'b1, rng: 1'b1, exp_busy: 1'b0};
        gtbl[2] = '{auth: 1'b0, lout: 1'b1, rng: 1'b1, exp_busy: 1'b0};
        gtbl[3] = '{auth: 1'b1, lout: 1'b0, rng: 1'b0, exp_busy: 1'b0};

        // Power-on reset
        #1;
        check("rst_outputs", {display_valid, display_symbol, busy, win, lose}, 0);
        tick();
        tick();
        check("rst_hold", {display_valid, display_symbol, busy, win, lose}, 0);
        rst      = 1'b0;
        m_lfsr   = 16'hACE1;
        auth_bit = 1'b1;

        // Start gating in IDLE
        for (int i = 0; i < 4; i++) begin
            auth_bit   = gtbl[i].auth;
            log_out    = gtbl[i].lout;
            rng_button = gtbl[i].rng;
            tick();
            m_lfsr = lfsr_next(m_lfsr);
            check("gate_busy", busy, gtbl[i].exp_busy);
        end
        auth_bit   = 1'b1;
        log_out    = 1'b0;
        rng_button = 1'b0;

        // Directed rounds
        for (int i = 0; i < 6; i++) begin
            play(rtbl[i].lvl, rtbl[i].err, rtbl[i].gap, rtbl[i].poke, gw, gl);
            check("tbl_win", gw, rtbl[i].exp_win);
            check("tbl_lose", gl, rtbl[i].exp_lose);
        end

        // Abort coinciding with a correct final entry
        idle(3);
        start(2);
        show_seq(-1);
        enter(exp_seq[0], 1'b0);
        enter(exp_seq[1], 1'b0);
        enter(exp_seq[2], 1'b1);
        check("abort_idle", {busy, win, lose}, 3'b000);
        m_lfsr = exp_st[2];
        tick();
        check("abort_nowin", {busy, win, lose}, 3'b000);
        m_lfsr = lfsr_next(m_lfsr);

        // Asynchronous reset in the middle of SHOW
        start(1);
        tick();
        tick();
        check("pre_rst_show", display_valid, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", {display_valid, display_symbol, busy, win, lose}, 0);
        check("rst_mid_lfsr", dut.lfsr_q, 16'hACE1);
        #2;
        rst      = 1'b0;
        m_lfsr   = 16'hACE1;
        auth_bit = 1'b0;
        idle(10);
        auth_bit = 1'b1;

        // Entry timeout behaviour
        start(1);
        show_seq(-1);
`ifdef ROUND_TIMEOUT_EN
        enter(exp_seq[0], 1'b0);
        check("tmo_first", {busy, win, lose}, 3'b100);
        bad = 0;
        for (int c = 1; c <= TMO; c++) begin
            tick();
            if (c < TMO && {busy, win, lose} != 3'b100) bad++;
        end
        check("tmo_early", bad, 0);
        check("tmo_lose", lose, 1);
        m_lfsr = exp_st[1];
        tick();
        check("tmo_after", busy, 0);
`else
        bad = 0;
        repeat (1000) begin
            tick();
            if ({busy, win, lose} != 3'b100) bad++;
        end
        check("no_tmo_busy", bad, 0);
        enter(exp_seq[0], 1'b0);
        enter(exp_seq[1], 1'b0);
        check("late_win", win, 1);
        m_lfsr = exp_st[1];
        tick();
        check("late_after", busy, 0);
`endif

        // Randomized rounds
        for (int r = 0; r < 25; r++) begin
            int lvl;
            int err;
            lvl = $urandom_range(0, 15);
            err = $urandom_range(0, lvl + 3);
            play(lvl, err, $urandom_range(0, 5), $urandom_range(0, lvl + 1), gw, gl);
            check("rand_win", gw, (err > lvl) ? 1 : 0);
            check("rand_lose", gl, (err > lvl) ? 0 : 1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
